recv: RTL and testbench
=======================

# recv

UART receiver: recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) from a serial line. It is the receive-side counterpart of the team's 16x-divided UART transmitter. It runs directly on the system clock `clk`, which is DIV times the baud rate, with no derived clock. Each received byte is presented with a one-cycle `valid` strobe to the consuming logic.

## Interface
- `DIV`, default 16: clk cycles per bit. Must be even and ≥4. The counter width is `$clog2(DIV)`.
- `clk`  in  1  system clock, DIV × baud.
- `rst`  in  1  reset, asynchronous, active-low.
- `in`  in  1  serial line; idles high; asynchronous to clk.
- `data`  out  8  last good byte received; reset 8'h00.
- `valid`  out  1  one-cycle pulse when `data` is updated; reset 0.
- `ferr`  out  1  one-cycle pulse on framing error (stop bit sampled 0); reset 0.
- `busy`  out  1  high whenever state ≠ IDLE; reset 0.

## Operation
- **Synchronizer:** two flops on `in`, both reset to 1. Output `s0` feeds a 3-deep history `s0,s1,s2`, all reset to 1.
- **Sample value `v`:** equals `s0` by default; see Configuration.
- **Counter:** `cnt` increments in every non-IDLE state and clears to 0 at each decision point.
- **Bit index:** `idx` runs 0..7.
- **States:** IDLE, START, DATA, STOP, WAIT_HIGH. Reset state is IDLE.
- **IDLE:** if `s0`==0, go to START with cnt←0.
- **START:** decision at cnt==DIV/2−1.
  - v==0: go to DATA, cnt←0, idx←0.
  - v==1: glitch; return to IDLE with no output.
- **DATA:** decision at cnt==DIV−1.
  - Shift right: `sh ← {v, sh[7:1]}`.
  - idx==7: go to STOP, cnt←0. Otherwise idx+1.
- **STOP:** decision at cnt==DIV−1.
  - v==1: `data←sh`, valid←1, go to IDLE.
  - v==0: `data` holds, ferr←1, go to WAIT_HIGH.
- **WAIT_HIGH:** stay until `s0`==1, then go to IDLE. This prevents a break condition from being taken as endless start bits.
- `valid` and `ferr` are never high in the same cycle, and each is high for exactly one cycle.
- There is no backpressure. The consumer must capture `data` on `valid`; a later frame overwrites it.

## Timing
- E0 is the clk edge at which the first synchronizer flop first captures `in`==0.
  - `s0` goes low at E1.
  - START is entered at E2.
  - The START decision is at E2+DIV/2.
  - Data bit k is decided at E2+DIV/2+DIV·(k+1).
  - The STOP decision is at E2+DIV/2+9·DIV. For DIV=16 this is E154.
- `valid` / `ferr` are registered at the STOP decision edge and high for the following cycle. With DIV=16, `valid` is high from E154 to E155.
- `busy` rises at E2 and falls at the STOP decision edge when the stop bit is good.
- Back-to-back frames: the next start falling edge may arrive DIV/2 cycles after the STOP decision, with no dead time required.
- Baud tolerance: decisions fall at bit centre ± DIV/2−1 cycles of accumulated drift.
- Reset mid-frame: all state, counter, shift register and outputs return to reset values immediately. The partial frame is discarded, no pulse is produced, and the synchronizer reads 1 after reset.
- Line low at reset release: detected as a start bit after 2 cycles. This is intended.

## Configuration
- **`RECV_MAJORITY_EN` defined:** v = majority(s0,s1,s2), i.e. the line sampled at the decision cycle and the two cycles before it. This rejects single-cycle glitches at the sample point. Decision cycles and latency are unchanged.
- **Undefined:** v = s0, a single sample. The s1 and s2 flops may be removed.

## Test plan
- **Clean frame:** send 0xA5 at DIV=16 with E0 at a known edge. Expect `valid` high exactly E154–E155, `data`==8'hA5, `ferr` never high, `busy` high E2–E154.
- **Back-to-back frames:** send 0x00 then 0xFF with the second start bit directly after the first stop bit. Expect two `valid` pulses exactly 160 cycles apart, `data` 0x00 then 0xFF.
- **Start glitch:** pulse `in` low for 4 cycles. Expect `busy` high E2 through the START decision at E10, then IDLE, with no `valid` and no `ferr`.
- **Framing error:**
  - Send 0x3C with stop bit 0 after a good 0x11. Expect a `ferr` pulse at E154, `data` stays 0x11, no `valid`.
  - Hold `in` low 100 more cycles. Expect no new frame until `in` returns high.
- **Reset mid-frame:** assert `rst` during data bit 3, then release and send 0x5A. Expect all outputs 0 during reset, no pulse for the aborted frame, then `valid` with `data`==0x5A.
- **Single-cycle glitch:** invert `in` for one cycle at the bit-2 sample point of 0x00.
  - With `RECV_MAJORITY_EN`: `data`==0x00.
  - Without it: `data`==0x04.

Source files
------------

// File: rtl/recv.sv
// 8N1 UART receiver running directly on clk = DIV x baud, one-cycle valid/ferr strobes.
// Optional `RECV_MAJORITY_EN`: bit decisions use a 3-sample majority instead of a single sample.
module recv #(
    parameter int DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in,
    output logic [7:0] data,
    output logic       valid,
    output logic       ferr,
    output logic       busy
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_e;

    logic meta_q, s0_q;
    logic v;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b1;
            s0_q   <= 1'b1;
        end else begin
            meta_q <= in;
            s0_q   <= meta_q;
        end
    end

`ifdef RECV_MAJORITY_EN
    logic s1_q, s2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= s0_q;
            s2_q <= s1_q;
        end
    end

    assign v = (s0_q & s1_q) | (s0_q & s2_q) | (s1_q & s2_q);
`else
    assign v = s0_q;
`endif

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      sh_q, sh_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        sh_d    = sh_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!s0_q) state_d = START;
            end
            START: begin
                // Half-bit wait puts every later decision at a bit centre.
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (!v) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    sh_d  = {v, sh_q[7:1]};
                    if (idx_q == 3'd7) state_d = STOP;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (v) begin
                        data_d  = sh_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // A held-low (break) line must not be re-read as fresh start bits.
                if (s0_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign data  = data_q;
    assign valid = valid_q;
    assign ferr  = ferr_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_recv.sv
// Directed bench for recv at DIV=16: frame timing, back-to-back, glitches, framing error, reset.
module tb_recv;

    localparam int DIV = 16;

    logic       clk;
    logic       rst;
    logic       line;
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       busy;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    int vq[$];
    int dq[$];
    int fq[$];
    int brq[$];
    int bfq[$];
    logic busy_prev = 1'b0;

    recv #(.DIV(DIV)) dut (
        .clk  (clk),
        .rst  (rst),
        .in   (line),
        .data (data),
        .valid(valid),
        .ferr (ferr),
        .busy (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // cyc seen at a negedge is the index of the edge that just registered the outputs.
    always @(negedge clk) begin
        if (valid) begin
            vq.push_back(cyc);
            dq.push_back(int'(data));
        end
        if (ferr) fq.push_back(cyc);
        if (busy && !busy_prev) brq.push_back(cyc);
        if (!busy && busy_prev) bfq.push_back(cyc);
        busy_prev <= busy;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic clr();
        @(posedge clk);
        vq.delete();
        dq.delete();
        fq.delete();
        brq.delete();
        bfq.delete();
    endtask

    // Drives len cycles of a 10-bit frame; bit c is captured by the first sync flop at E(e0+c).
    task automatic send(input logic [7:0] b, input logic stopb, input int len,
                        input int glitch, output int e0);
        logic [9:0] fr;
        fr = {stopb, b, 1'b0};
        e0 = 0;
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            if (c == 0) e0 = cyc + 1;
            line = fr[c / DIV] ^ (c == glitch);
        end
    endtask

    int e0, e0b;
    logic [7:0] glitch_exp;

    initial begin
        rst  = 1'b0;
        line = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data",  32'(data),  32'h00);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_ferr",  32'(ferr),  32'h0);
        check("rst_busy",  32'(busy),  32'h0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // clean 0xA5
        clr();
        send(8'hA5, 1'b1, 10 * DIV, -1, e0);
        repeat (4) @(negedge clk);
        check("a5_nvalid",   32'(vq.size()), 32'd1);
        check("a5_vcycle",   32'(qat(vq, 0)), 32'(e0 + 154));
        check("a5_data",     32'(qat(dq, 0)), 32'hA5);
        check("a5_nferr",    32'(fq.size()), 32'd0);
        check("a5_busyrise", 32'(qat(brq, 0)), 32'(e0 + 2));
        check("a5_busyfall", 32'(qat(bfq, 0)), 32'(e0 + 154));
        check("a5_hold",     32'(data), 32'hA5);

        // back-to-back 0x00 then 0xFF
        clr();
        send(8'h00, 1'b1, 10 * DIV, -1, e0);
        send(8'hFF, 1'b1, 10 * DIV, -1, e0b);
        repeat (4) @(negedge clk);
        check("b2b_nvalid", 32'(vq.size()), 32'd2);
        check("b2b_first",  32'(qat(vq, 0)), 32'(e0 + 154));
        check("b2b_gap",    32'(qat(vq, 1) - qat(vq, 0)), 32'd160);
        check("b2b_d0",     32'(qat(dq, 0)), 32'h00);
        check("b2b_d1",     32'(qat(dq, 1)), 32'hFF);
        check("b2b_nferr",  32'(fq.size()), 32'd0);

        // start glitch: 4 low cycles
        clr();
        send(8'hFF, 1'b1, 4, -1, e0);
        @(negedge clk);
        line = 1'b1;
        repeat (30) @(negedge clk);
        check("sg_busyrise", 32'(qat(brq, 0)), 32'(e0 + 2));
        check("sg_busyfall", 32'(qat(bfq, 0)), 32'(e0 + 10));
        check("sg_nvalid",   32'(vq.size()), 32'd0);
        check("sg_nferr",    32'(fq.size()), 32'd0);

        // framing error after a good 0x11, then a held break
        clr();
        send(8'h11, 1'b1, 10 * DIV, -1, e0);
        send(8'h3C, 1'b0, 10 * DIV, -1, e0b);
        repeat (100) @(negedge clk);
        check("fe_nferr",   32'(fq.size()), 32'd1);
        check("fe_fcycle",  32'(qat(fq, 0)), 32'(e0b + 154));
        check("fe_nvalid",  32'(vq.size()), 32'd1);
        check("fe_good",    32'(qat(dq, 0)), 32'h11);
        check("fe_data",    32'(data), 32'h11);
        check("fe_busy_lo", 32'(busy), 32'h1);
        line = 1'b1;
        repeat (6) @(negedge clk);
        check("fe_busy_hi", 32'(busy), 32'h0);
        check("fe_nferr2",  32'(fq.size()), 32'd1);
        check("fe_nvalid2", 32'(vq.size()), 32'd1);

        // reset during data bit 3, then 0x5A
        clr();
        send(8'h00, 1'b1, 70, -1, e0);
        #1;
        rst  = 1'b0;
        line = 1'b1;
        #1;
        check("mr_data",  32'(data),  32'h00);
        check("mr_valid", 32'(valid), 32'h0);
        check("mr_ferr",  32'(ferr),  32'h0);
        check("mr_busy",  32'(busy),  32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        send(8'h5A, 1'b1, 10 * DIV, -1, e0);
        repeat (4) @(negedge clk);
        check("mr_nvalid", 32'(vq.size()), 32'd1);
        check("mr_vcycle", 32'(qat(vq, 0)), 32'(e0 + 154));
        check("mr_d",      32'(qat(dq, 0)), 32'h5A);
        check("mr_nferr",  32'(fq.size()), 32'd0);

        // one-cycle glitch at the bit-2 sample point of 0x00
`ifdef RECV_MAJORITY_EN
        glitch_exp = 8'h00;
`else
        glitch_exp = 8'h04;
`endif
        clr();
        send(8'h00, 1'b1, 10 * DIV, 56, e0);
        repeat (4) @(negedge clk);
        check("gl_nvalid", 32'(vq.size()), 32'd1);
        check("gl_data",   32'(qat(dq, 0)), 32'(glitch_exp));
        check("gl_nferr",  32'(fq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
